// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_fifo: FIFO-buffered UART transmitter, optional parity bit when   |
// | UART_TX_FIFO_PARITY_EN is defined.                    Revision: 1.0      |
// +--------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int MAIN_CLK   = 20000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_,
  input  logic                          tx_req,
  output logic                          tx_ready,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          parity_odd,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BAUD_DIVIDE = MAIN_CLK / BAUD;
  localparam int CNT_W       = $clog2(BAUD_DIVIDE);
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int LVL_W       = PTR_W + 1;

  localparam logic [CNT_W-1:0] c_BAUD_RELOAD = CNT_W'(BAUD_DIVIDE - 1);
  localparam logic [LVL_W-1:0] c_FULL_LEVEL  = LVL_W'(FIFO_DEPTH);
  localparam logic [3:0]       c_LAST_BIT    = 4'(DATA_BITS - 1);
  localparam logic             c_LAST_STOP   = 1'(STOP_BITS - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
`ifdef UART_TX_FIFO_PARITY_EN
  localparam logic [2:0] c_PARITY = 3'd3;
`endif
  localparam logic [2:0] c_STOP   = 3'd4;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;

  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_baud_cnt;
  logic [3:0]           r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_uart_tx;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_done;
  logic                 w_frame_done;
  logic                 w_line;
  logic [DATA_BITS-1:0] w_head;

  assign tx_ready     = (r_level != c_FULL_LEVEL);
  assign fifo_level   = r_level;
  assign tx_busy      = (r_state != c_IDLE);
  assign uart_tx      = r_uart_tx;

  assign w_push       = tx_req && tx_ready;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_bit_done   = (r_baud_cnt == '0);
  assign w_frame_done = (r_state == c_STOP) && w_bit_done && (r_stop_idx == c_LAST_STOP);
  // Pop from idle, or straight out of the last stop bit so frames abut.
  assign w_pop        = (r_level != '0) && ((r_state == c_IDLE) || w_frame_done);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef UART_TX_FIFO_PARITY_EN
  logic r_parity;

  // Parity mode is captured with the word so mid-frame changes are harmless.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_parity <= (^w_head) ^ parity_odd;
    end
  end
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = parity_odd;
`endif

  always_comb begin
    w_line = 1'b1;
    case (r_state)
      c_START:  w_line = 1'b0;
      c_DATA:   w_line = r_shift[0];
`ifdef UART_TX_FIFO_PARITY_EN
      c_PARITY: w_line = r_parity;
`endif
      default:  w_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state    <= c_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_uart_tx  <= 1'b1;
    end else begin
      // The line follows the state one clock later.
      r_uart_tx <= w_line;
      if (w_pop) begin
        r_state    <= c_START;
        r_baud_cnt <= c_BAUD_RELOAD;
        r_shift    <= w_head;
        r_bit_idx  <= '0;
        r_stop_idx <= 1'b0;
      end else if (r_state != c_IDLE) begin
        if (!w_bit_done) begin
          r_baud_cnt <= r_baud_cnt - 1'b1;
        end else begin
          r_baud_cnt <= c_BAUD_RELOAD;
          case (r_state)
            c_START: r_state <= c_DATA;
            c_DATA: begin
              r_shift <= r_shift >> 1;
              if (r_bit_idx == c_LAST_BIT) begin
                r_bit_idx <= '0;
`ifdef UART_TX_FIFO_PARITY_EN
                r_state   <= c_PARITY;
`else
                r_state   <= c_STOP;
`endif
              end else begin
                r_bit_idx <= r_bit_idx + 1'b1;
              end
            end
`ifdef UART_TX_FIFO_PARITY_EN
            c_PARITY: r_state <= c_STOP;
`endif
            c_STOP: begin
              if (r_stop_idx == c_LAST_STOP) begin
                r_state    <= c_IDLE;
                r_baud_cnt <= '0;
              end else begin
                r_stop_idx <= r_stop_idx + 1'b1;
              end
            end
            default: begin
              r_state    <= c_IDLE;
              r_baud_cnt <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_fifo: checks 8N1 and 5-bit/2-stop instances of uart_tx_fifo   |
// | against a queue-based frame model.                    Revision: 1.0      |
// +--------------------------------------------------------------------------+
module tb_uart_tx_fifo;

  localparam int BD    = 16;
  localparam int DEPTH = 4;
`ifdef UART_TX_FIFO_PARITY_EN
  localparam int PB = 1;
  localparam logic [15:0] c_F55      = 16'h04AA;
  localparam logic [15:0] c_F07_EVEN = 16'h060E;
  localparam logic [15:0] c_F07_ODD  = 16'h040E;
  localparam logic [15:0] c_F1F      = 16'h01FE;
`else
  localparam int PB = 0;
  localparam logic [15:0] c_F55      = 16'h02AA;
  localparam logic [15:0] c_F07_EVEN = 16'h020E;
  localparam logic [15:0] c_F07_ODD  = 16'h020E;
  localparam logic [15:0] c_F1F      = 16'h00FE;
`endif
  localparam int FR0 = 10 + PB;
  localparam int FR1 = 8 + PB;

  logic       clk    = 1'b0;
  logic       reset_ = 1'b0;
  logic       tx_req     [2];
  logic [8:0] tx_data    [2];
  logic       parity_odd [2];
  logic       tx_ready   [2];
  logic       uart_tx    [2];
  logic       tx_busy    [2];
  logic [2:0] fifo_level [2];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int DB = (g == 0) ? 8 : 5;
    localparam int SB = (g == 0) ? 1 : 2;
    localparam int FB = 1 + DB + PB + SB;

    uart_tx_fifo #(
      .MAIN_CLK(16), .BAUD(1), .DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
    ) u_dut (
      .clk        (clk),
      .reset_     (reset_),
      .tx_req     (tx_req[g]),
      .tx_ready   (tx_ready[g]),
      .tx_data    (tx_data[g][DB-1:0]),
      .parity_odd (parity_odd[g]),
      .uart_tx    (uart_tx[g]),
      .tx_busy    (tx_busy[g]),
      .fifo_level (fifo_level[g])
    );

    int unsigned m_q[$];
    bit          m_active = 1'b0;
    int          m_cyc    = 0;
    bit [15:0]   m_frame  = '1;
    bit          m_line   = 1'b1;

    // Line level of each bit period: start, data LSB first, parity, stops.
    function automatic bit [15:0] frame_of(input int unsigned w, input bit po);
      bit [15:0] f = '1;
      int ones = 0;
      f[0] = 1'b0;
      for (int i = 0; i < DB; i++) begin
        f[1+i] = w[i];
        ones += int'(w[i]);
      end
      if (PB == 1) f[1+DB] = bit'(ones % 2) ^ po;
      return f;
    endfunction

    initial forever begin
      @(posedge clk or negedge reset_);
      if (!reset_) begin
        m_q.delete();
        m_active = 1'b0;
        m_cyc    = 0;
        m_line   = 1'b1;
      end else begin : upd
        int pre;
        bit push;
        pre  = m_q.size();
        push = tx_req[g] && (pre != DEPTH);
        m_line = m_active ? m_frame[m_cyc / BD] : 1'b1;
        if (m_active) begin
          m_cyc++;
          if (m_cyc == FB * BD) m_active = 1'b0;
        end
        if (!m_active && pre > 0) begin
          m_frame  = frame_of(m_q.pop_front(), parity_odd[g]);
          m_active = 1'b1;
          m_cyc    = 0;
        end
        if (push) m_q.push_back(int'(tx_data[g]) & ((1 << DB) - 1));
      end
    end

    initial forever begin
      @(negedge clk);
      if (reset_) begin
        check($sformatf("u%0d uart_tx", g), 32'(uart_tx[g]), 32'(m_line));
        check($sformatf("u%0d tx_busy", g), 32'(tx_busy[g]), 32'(m_active));
        check($sformatf("u%0d fifo_level", g), 32'(fifo_level[g]), 32'(m_q.size()));
        check($sformatf("u%0d tx_ready", g), 32'(tx_ready[g]), 32'(m_q.size() != DEPTH));
      end
    end
  end

  task automatic push_one(input int g, input logic [8:0] d);
    tx_req[g]  = 1'b1;
    tx_data[g] = d;
    @(negedge clk);
    tx_req[g]  = 1'b0;
  endtask

  // Entered at the negedge after the accepting edge of a word into an idle block.
  task automatic frame_check(input int g, input logic [15:0] bits, input int n);
    @(negedge clk);
    parity_odd[g] = ~parity_odd[g];
    check($sformatf("u%0d line before start", g), 32'(uart_tx[g]), 1);
    check($sformatf("u%0d busy at pop", g), 32'(tx_busy[g]), 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check($sformatf("u%0d bit%0d first cycle", g, k), 32'(uart_tx[g]), 32'(bits[k]));
      repeat (BD - 2) @(negedge clk);
      if (k == n - 1) check($sformatf("u%0d busy last cycle", g), 32'(tx_busy[g]), 1);
      @(negedge clk);
      check($sformatf("u%0d bit%0d last cycle", g, k), 32'(uart_tx[g]), 32'(bits[k]));
    end
    check($sformatf("u%0d busy after frame", g), 32'(tx_busy[g]), 0);
    parity_odd[g] = ~parity_odd[g];
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int c0;
    int guard;
    int bad;
    for (int g = 0; g < 2; g++) begin
      tx_req[g] = 1'b0;
      tx_data[g] = '0;
      parity_odd[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("reset uart_tx", 32'(uart_tx[g]), 1);
      check("reset tx_busy", 32'(tx_busy[g]), 0);
      check("reset tx_ready", 32'(tx_ready[g]), 1);
      check("reset fifo_level", 32'(fifo_level[g]), 0);
    end

    // First edge after release accepts a push.
    reset_ = 1'b1;
    push_one(0, 9'h055);
    check("first push level", 32'(fifo_level[0]), 1);
    frame_check(0, c_F55, FR0);

    parity_odd[0] = 1'b0;
    push_one(0, 9'h007);
    frame_check(0, c_F07_EVEN, FR0);
    parity_odd[0] = 1'b1;
    push_one(0, 9'h007);
    frame_check(0, c_F07_ODD, FR0);
    parity_odd[0] = 1'b0;

    push_one(1, 9'h01F);
    frame_check(1, c_F1F, FR1);

    // Back-to-back burst, then hold tx_req against a full FIFO.
    c0 = 0;
    tx_req[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_data[0] = 9'(8'hA0 + i);
      @(negedge clk);
      if (i == 0) c0 = cyc;
    end
    check("full level", 32'(fifo_level[0]), 4);
    check("full ready", 32'(tx_ready[0]), 0);
    for (int i = 0; i < 20; i++) begin
      tx_data[0] = 9'(8'hE0 + i);
      @(negedge clk);
    end
    check("full after hold", 32'(fifo_level[0]), 4);
    tx_data[0] = 9'h03C;
    guard = 0;
    while (!tx_ready[0] && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("ready rise timeout", 32'(guard < 400), 1);
    @(negedge clk);
    tx_req[0] = 1'b0;
    check("push after ready rise", 32'(fifo_level[0]), 4);
    guard = 0;
    while (tx_busy[0] && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("burst busy span", 32'(cyc - c0), 32'(1 + 6 * FR0 * BD));
    check("burst drained level", 32'(fifo_level[0]), 0);

    // Reset in the middle of DATA with two words queued.
    tx_req[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_data[0] = 9'(8'h5A + i);
      @(negedge clk);
    end
    tx_req[0] = 1'b0;
    repeat (30) @(negedge clk);
    check("pre-reset level", 32'(fifo_level[0]), 2);
    check("pre-reset busy", 32'(tx_busy[0]), 1);
    #2 reset_ = 1'b0;
    #1;
    check("abort uart_tx", 32'(uart_tx[0]), 1);
    check("abort level", 32'(fifo_level[0]), 0);
    check("abort busy", 32'(tx_busy[0]), 0);
    check("abort ready", 32'(tx_ready[0]), 1);
    repeat (3) @(negedge clk);
    reset_ = 1'b1;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_busy[0] || !uart_tx[0]) bad++;
    end
    check("no frame after reset", 32'(bad), 0);

    // Randomized traffic on both instances.
    for (int i = 0; i < 6000; i++) begin
      for (int g = 0; g < 2; g++) begin
        tx_req[g]     = ($urandom_range(0, 99) < ((i < 3000) ? 2 : 25));
        tx_data[g]    = 9'($urandom);
        parity_odd[g] = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    for (int g = 0; g < 2; g++) tx_req[g] = 1'b0;
    guard = 0;
    while ((tx_busy[0] || tx_busy[1] || fifo_level[0] != 0 || fifo_level[1] != 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("final drain", 32'(guard < 3000), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL expose parameter MAIN_CLK, default 20000000, meaning the clk frequency in Hz.
REQ-002 The block SHALL expose parameter BAUD, default 115200, meaning the line bit rate; BAUD_DIVIDE = MAIN_CLK/BAUD, truncated, and SHALL be at least 2.
REQ-003 The block SHALL expose parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-004 The block SHALL expose parameter STOP_BITS, default 1, meaning stop bits per frame, legal values 1 or 2.
REQ-005 The block SHALL expose parameter FIFO_DEPTH, default 4, meaning word capacity, a power of two of at least 2.
REQ-006 The block SHALL have ports: clk in 1 (sole clock, all state on its rising edge); reset_ in 1 (asynchronous, active-low reset).
REQ-007 The block SHALL have ports: tx_req in 1 (write request); tx_ready out 1 (FIFO can accept); tx_data in DATA_BITS (word to send, LSB first).
REQ-008 The block SHALL have ports: parity_odd in 1 (1=odd, 0=even parity); uart_tx out 1 (serial line, idle high); tx_busy out 1 (frame in progress); fifo_level out clog2(FIFO_DEPTH)+1 (words held).

Function
REQ-009 tx_ready SHALL equal (fifo_level != FIFO_DEPTH) and SHALL depend only on registered state.
REQ-010 A word SHALL be written on every rising edge with tx_req=1 and tx_ready=1; tx_req while tx_ready=0 SHALL be ignored with no error or side effect.
REQ-011 The FIFO SHALL be first-in first-out; read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL change +1 on push only, -1 on pop only, 0 on a simultaneous push and pop.
REQ-012 The serializer SHALL be an FSM with states IDLE, START, DATA, PARITY and STOP.
REQ-013 In IDLE with fifo_level>0, the FSM SHALL pop the head word and enter START on the same edge.
REQ-014 A word pushed into an empty FIFO while the FSM is in IDLE SHALL drive uart_tx low on the second rising edge after the accepting edge.
REQ-015 Each bit period SHALL last exactly BAUD_DIVIDE clk cycles, timed by a counter reloaded to BAUD_DIVIDE-1 on entry to every bit and idle (not counting) in IDLE.
REQ-016 Line levels SHALL be: START low; DATA bits tx_data[0] first through tx_data[DATA_BITS-1]; PARITY (when present) the parity bit; STOP high for STOP_BITS periods.
REQ-017 At the end of the final STOP period the FSM SHALL pop and enter START directly if fifo_level>0, leaving zero idle cycles between frames, and SHALL enter IDLE otherwise.
REQ-018 tx_busy SHALL be 1 in every state except IDLE.
REQ-019 uart_tx SHALL be driven from a flop and SHALL be high in IDLE.
REQ-020 parity_odd SHALL be sampled once per frame, at the pop edge; changes mid-frame SHALL NOT affect the frame in flight.

Reset
REQ-021 Asserting reset_ low SHALL immediately force: uart_tx=1, tx_busy=0, tx_ready=1, fifo_level=0, FSM=IDLE, FIFO pointers=0, baud counter=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame and discard all FIFO contents; no partial frame SHALL resume after release.
REQ-023 The first push SHALL be accepted on the first rising edge with reset_ high.

Configuration
REQ-024 Macro UART_TX_FIFO_PARITY_EN defined SHALL insert the PARITY state after DATA, sending XOR of the data bits XOR parity_odd.
REQ-025 Without UART_TX_FIFO_PARITY_EN, the PARITY state and parity logic SHALL be absent, DATA SHALL go directly to STOP, and parity_odd SHALL be ignored.

Verification
REQ-026 Bench SHALL use MAIN_CLK=16, BAUD=1, DATA_BITS=8, STOP_BITS=1, no macro: push 0x55 into idle block -> uart_tx low 2 edges later, then 0,1,0,1,0,1,0,1 start/data pattern plus stop bit, 16 cycles per bit, tx_busy low after 160 cycles.
REQ-027 Bench SHALL push 4 words back-to-back (FIFO_DEPTH=4) -> tx_ready low while fifo_level=4, frames contiguous with no idle cycle, fifo_level counts down to 0.
REQ-028 Bench SHALL define UART_TX_FIFO_PARITY_EN with parity_odd=0 and send 0x07 -> parity bit 1; with parity_odd=1 -> parity bit 0; frame 11 bits.
REQ-029 Bench SHALL use DATA_BITS=5, STOP_BITS=2 and send 0x1F -> low, five high, two high stop bits, total 8 bit periods.
REQ-030 Bench SHALL assert reset_ low mid-DATA with 2 words queued -> uart_tx=1 and fifo_level=0 immediately, no further frames after release.
REQ-031 Bench SHALL hold fifo_level=4 and keep tx_req=1 for 20 cycles -> no word lost or overwritten, and the next push is accepted on the cycle after tx_ready rises.
